// File: rtl/neopixel_pkg.sv
// Shared constants and types for the NeoPixel double-banked pixel buffer.
// Pixel layout is {B, R, G}, one byte per channel, G in the low byte.
package neopixel_pkg;

    localparam int PIXEL_WIDTH = 24;

    typedef enum logic [1:0] {
        CH_GREEN = 2'd0,
        CH_RED   = 2'd1,
        CH_BLUE  = 2'd2,
        CH_RSVD  = 2'd3
    } channel_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } state_e;

    function automatic logic [7:0] pixel_lane(input logic [PIXEL_WIDTH-1:0] px,
                                              input logic [1:0]             ch);
        case (ch)
            CH_GREEN: return px[7:0];
            CH_RED:   return px[15:8];
            CH_BLUE:  return px[23:16];
            default:  return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/neopixel_bank_ram.sv
// One pixel bank: byte-lane synchronous write, combinational read, async clear.
// Out-of-range indices read as zero and never write.
module neopixel_bank_ram
    import neopixel_pkg::*;
#(
    parameter int PIXELS_MAX  = 3,
    parameter int PIXELS_BITS = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [PIXELS_BITS-1:0] wr_idx_i,
    input  logic [1:0]             wr_lane_i,
    input  logic [7:0]             wr_data_i,
    input  logic [PIXELS_BITS-1:0] rd_idx_i,
    output logic [PIXEL_WIDTH-1:0] rd_data_o
);

    localparam logic [PIXELS_BITS:0] DEPTH = (PIXELS_BITS+1)'(PIXELS_MAX);

    logic [PIXEL_WIDTH-1:0] mem_q [PIXELS_MAX];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PIXELS_MAX; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i && ({1'b0, wr_idx_i} < DEPTH)) begin
            case (wr_lane_i)
                CH_GREEN: mem_q[wr_idx_i][7:0]   <= wr_data_i;
                CH_RED:   mem_q[wr_idx_i][15:8]  <= wr_data_i;
                CH_BLUE:  mem_q[wr_idx_i][23:16] <= wr_data_i;
                default:  ;
            endcase
        end
    end

    assign rd_data_o = ({1'b0, rd_idx_i} < DEPTH) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/neopixel_pixel_buffer.sv
// Double-banked pixel store feeding the NeoPixel serializer. Host writes the back
// bank; FRAME_START swaps banks and streams the front bank pixel by pixel.
//
// state   | meaning
// IDLE    | no frame in flight, waiting for FRAME_START
// FETCH   | latch front[index] and its LAST flag into the output registers
// PRESENT | pixel offered to the serializer, waiting for PIXEL_REQ
module neopixel_pixel_buffer
    import neopixel_pkg::*;
#(
    parameter int PIXELS_MAX  = 3,
    parameter int PIXELS_BITS = 2
) (
    input  logic                   CLK_10MHZ,
    input  logic                   RESET,
    input  logic [PIXELS_BITS+1:0] BUS_ADDR,
    input  logic [7:0]             BUS_DATA_W,
    input  logic                   BUS_WRITE,
    output logic [7:0]             BUS_DATA_R,
    input  logic                   FRAME_START,
    output logic                   FRAME_BUSY,
    output logic [PIXEL_WIDTH-1:0] PIXEL_VALUE,
    output logic                   PIXEL_VALID,
    output logic                   PIXEL_LAST,
    input  logic                   PIXEL_REQ
);

    localparam logic [PIXELS_BITS:0]   DEPTH    = (PIXELS_BITS+1)'(PIXELS_MAX);
    localparam logic [PIXELS_BITS-1:0] LAST_IDX = PIXELS_BITS'(PIXELS_MAX - 1);

    state_e                 state_q, state_d;
    logic                   bank_sel_q, bank_sel_d;
    logic [PIXELS_BITS-1:0] idx_q, idx_d;
    logic [PIXEL_WIDTH-1:0] value_q, value_d;
    logic                   last_q, last_d;
    logic                   valid_q, valid_d;
    logic [7:0]             data_r_q, data_r_d;

    logic [PIXELS_BITS-1:0] addr_idx;
    logic [1:0]             addr_ch;
    logic                   addr_ok;
    logic                   wr_ok;
    logic [PIXELS_BITS-1:0] rd_idx0, rd_idx1;
    logic [PIXEL_WIDTH-1:0] rd_data0, rd_data1;
    logic [PIXEL_WIDTH-1:0] front_px, back_px;

    assign {addr_idx, addr_ch} = BUS_ADDR;
    assign addr_ok = ({1'b0, addr_idx} < DEPTH) && (addr_ch != CH_RSVD);
    assign wr_ok   = BUS_WRITE && addr_ok;

    // bank_sel names the front bank; each bank's read port serves the FSM when
    // it is front and the host readback when it is back.
    assign rd_idx0  = bank_sel_q ? addr_idx : idx_q;
    assign rd_idx1  = bank_sel_q ? idx_q    : addr_idx;
    assign front_px = bank_sel_q ? rd_data1 : rd_data0;
    assign back_px  = bank_sel_q ? rd_data0 : rd_data1;

    neopixel_bank_ram #(
        .PIXELS_MAX (PIXELS_MAX),
        .PIXELS_BITS(PIXELS_BITS)
    ) u_bank0 (
        .clk_i    (CLK_10MHZ),
        .rst_i    (RESET),
        .wr_en_i  (wr_ok && bank_sel_q),
        .wr_idx_i (addr_idx),
        .wr_lane_i(addr_ch),
        .wr_data_i(BUS_DATA_W),
        .rd_idx_i (rd_idx0),
        .rd_data_o(rd_data0)
    );

    neopixel_bank_ram #(
        .PIXELS_MAX (PIXELS_MAX),
        .PIXELS_BITS(PIXELS_BITS)
    ) u_bank1 (
        .clk_i    (CLK_10MHZ),
        .rst_i    (RESET),
        .wr_en_i  (wr_ok && !bank_sel_q),
        .wr_idx_i (addr_idx),
        .wr_lane_i(addr_ch),
        .wr_data_i(BUS_DATA_W),
        .rd_idx_i (rd_idx1),
        .rd_data_o(rd_data1)
    );

    assign data_r_d = addr_ok ? pixel_lane(back_px, addr_ch) : 8'h00;

    always_comb begin
        state_d    = state_q;
        bank_sel_d = bank_sel_q;
        idx_d      = idx_q;
        value_d    = value_q;
        last_d     = last_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (FRAME_START) begin
                    bank_sel_d = !bank_sel_q;
                    idx_d      = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                value_d = front_px;
                last_d  = (idx_q == LAST_IDX);
                valid_d = 1'b0;
                state_d = PRESENT;
            end
            PRESENT: begin
                // VALID rises one cycle after entering PRESENT, so a REQ in that
                // first cycle is ignored and the refill gap is two cycles.
                if (valid_q && PIXEL_REQ) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_10MHZ or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            bank_sel_q <= 1'b0;
            idx_q      <= '0;
            value_q    <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_r_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            bank_sel_q <= bank_sel_d;
            idx_q      <= idx_d;
            value_q    <= value_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            data_r_q   <= data_r_d;
        end
    end

    assign FRAME_BUSY  = (state_q != IDLE);
    assign PIXEL_VALUE = value_q;
    assign PIXEL_VALID = valid_q;
    assign PIXEL_LAST  = last_q;
    assign BUS_DATA_R  = data_r_q;

endmodule

// File: tb/tb_neopixel_pixel_buffer.sv
// Self-checking bench: a two-bank array model with a front-bank pointer predicts
// readback bytes and the pixel sequence of every frame.
module tb_neopixel_pixel_buffer;

    logic        clk;
    logic        RESET;
    logic [3:0]  BUS_ADDR;
    logic [7:0]  BUS_DATA_W;
    logic        BUS_WRITE;
    logic [7:0]  BUS_DATA_R;
    logic        FRAME_START;
    logic        FRAME_BUSY;
    logic [23:0] PIXEL_VALUE;
    logic        PIXEL_VALID;
    logic        PIXEL_LAST;
    logic        PIXEL_REQ;

    neopixel_pixel_buffer #(.PIXELS_MAX(3), .PIXELS_BITS(2)) dut (
        .CLK_10MHZ  (clk),
        .RESET      (RESET),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_DATA_W (BUS_DATA_W),
        .BUS_WRITE  (BUS_WRITE),
        .BUS_DATA_R (BUS_DATA_R),
        .FRAME_START(FRAME_START),
        .FRAME_BUSY (FRAME_BUSY),
        .PIXEL_VALUE(PIXEL_VALUE),
        .PIXEL_VALID(PIXEL_VALID),
        .PIXEL_LAST (PIXEL_LAST),
        .PIXEL_REQ  (PIXEL_REQ)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model: mb[bank][pixel], msel = front bank
    logic [23:0] mb [2][3];
    bit          msel;
    logic [23:0] obs [3];

    function automatic logic [7:0] m_byte(input bit b, input logic [3:0] a);
        int i = int'(a[3:2]);
        int c = int'(a[1:0]);
        if (i >= 3 || c == 3) return 8'h00;
        return mb[b][i][c*8 +: 8];
    endfunction

    task automatic m_write(input logic [3:0] a, input logic [7:0] d);
        int i = int'(a[3:2]);
        int c = int'(a[1:0]);
        if (i < 3 && c != 3) mb[!msel][i][c*8 +: 8] = d;
    endtask

    task automatic m_clear();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 3; i++) mb[b][i] = 24'h0;
        msel = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        BUS_ADDR   = a;
        BUS_DATA_W = d;
        BUS_WRITE  = 1'b1;
        cyc();
        m_write(a, d);
        BUS_WRITE = 1'b0;
    endtask

    task automatic write_pixel(input int p, input logic [23:0] px);
        bus_write(4'(p*4 + 0), px[7:0]);
        bus_write(4'(p*4 + 1), px[15:8]);
        bus_write(4'(p*4 + 2), px[23:16]);
    endtask

    task automatic check_read(input logic [3:0] a, input string name);
        logic [7:0] exp;
        BUS_ADDR = a;
        cyc();
        exp = m_byte(!msel, a);
        tests++;
        if (BUS_DATA_R !== exp) begin
            fails++;
            $display("FAIL %s addr=%0h got=%02h exp=%02h", name, a, BUS_DATA_R, exp);
        end
    endtask

    task automatic run_frame(input int delay, input bit early_req, input bit poke_start,
                             input bit mid_wr, input logic [3:0] mw_a, input logic [7:0] mw_d,
                             input bit sim_wr, input logic [3:0] sw_a, input logic [7:0] sw_d);
        logic [23:0] snap [3];
        int k;
        bit stable;
        FRAME_START = 1'b1;
        if (sim_wr) begin
            BUS_ADDR = sw_a; BUS_DATA_W = sw_d; BUS_WRITE = 1'b1;
        end
        cyc();
        if (sim_wr) m_write(sw_a, sw_d);
        msel = !msel;
        for (int i = 0; i < 3; i++) snap[i] = mb[msel][i];
        FRAME_START = 1'b0;
        BUS_WRITE   = 1'b0;
        tests++;
        if (FRAME_BUSY !== 1'b1) begin
            fails++;
            $display("FAIL busy_rise got=%b exp=1", FRAME_BUSY);
        end
        for (int p = 0; p < 3; p++) begin
            k = 0;
            PIXEL_REQ = early_req;
            while (PIXEL_VALID !== 1'b1 && k < 20) begin
                cyc();
                k++;
            end
            PIXEL_REQ = 1'b0;
            tests++;
            if (k != 2) begin
                fails++;
                $display("FAIL valid_latency pixel=%0d got=%0d edges exp=2", p, k);
                if (k >= 20) return;
            end
            obs[p] = PIXEL_VALUE;
            tests++;
            if (PIXEL_VALUE !== snap[p] || PIXEL_LAST !== (p == 2)) begin
                fails++;
                $display("FAIL pixel_value pixel=%0d got=%06h/last=%b exp=%06h/last=%b",
                         p, PIXEL_VALUE, PIXEL_LAST, snap[p], (p == 2));
            end
            stable = 1'b1;
            for (int d = 0; d < delay; d++) begin
                if (p == 0 && d == 0 && mid_wr) begin
                    bus_write(mw_a, mw_d);
                end else if (p == 1 && d == 0 && poke_start) begin
                    FRAME_START = 1'b1;
                    cyc();
                    FRAME_START = 1'b0;
                end else begin
                    cyc();
                end
                if (PIXEL_VALUE !== snap[p] || PIXEL_VALID !== 1'b1 ||
                    PIXEL_LAST !== (p == 2) || FRAME_BUSY !== 1'b1) stable = 1'b0;
            end
            tests++;
            if (!stable) begin
                fails++;
                $display("FAIL hold_stable pixel=%0d got=%06h/v=%b exp=%06h/v=1",
                         p, PIXEL_VALUE, PIXEL_VALID, snap[p]);
            end
            PIXEL_REQ = 1'b1;
            cyc();
            PIXEL_REQ = 1'b0;
            tests++;
            if (PIXEL_VALID !== 1'b0 || FRAME_BUSY !== (p != 2)) begin
                fails++;
                $display("FAIL after_req pixel=%0d got valid=%b busy=%b exp valid=0 busy=%b",
                         p, PIXEL_VALID, FRAME_BUSY, (p != 2));
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        BUS_ADDR = 4'h0; BUS_DATA_W = 8'h00; BUS_WRITE = 1'b0;
        FRAME_START = 1'b0; PIXEL_REQ = 1'b0;
        m_clear();
        @(negedge clk);
        tests++;
        if (PIXEL_VALID !== 1'b0 || FRAME_BUSY !== 1'b0 || PIXEL_VALUE !== 24'h0 ||
            PIXEL_LAST !== 1'b0 || BUS_DATA_R !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs got v=%b b=%b val=%06h l=%b r=%02h exp all zero",
                     PIXEL_VALID, FRAME_BUSY, PIXEL_VALUE, PIXEL_LAST, BUS_DATA_R);
        end
        RESET = 1'b0;
        cyc();
        check_read(4'h0, "reset_readback");
    endtask

    task automatic test_single_pixel();
        bus_write(4'h0, 8'hD5);
        bus_write(4'h1, 8'h00);
        bus_write(4'h2, 8'hFF);
        check_read(4'h0, "rb_green");
        check_read(4'h2, "rb_blue");
        run_frame(2, 0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
        tests++;
        if (obs[0] !== 24'hFF00D5) begin
            fails++;
            $display("FAIL single_pixel got=%06h exp=ff00d5", obs[0]);
        end
    endtask

    task automatic test_three_pixels();
        write_pixel(0, 24'hFF00D5);
        write_pixel(1, 24'h008800);
        write_pixel(2, 24'h000090);
        run_frame(288, 0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
        tests++;
        if (obs[0] !== 24'hFF00D5 || obs[1] !== 24'h008800 || obs[2] !== 24'h000090) begin
            fails++;
            $display("FAIL three_pixels got=%06h %06h %06h exp=ff00d5 008800 000090",
                     obs[0], obs[1], obs[2]);
        end
    endtask

    task automatic test_mid_frame_write();
        write_pixel(0, 24'hFF00D5);
        write_pixel(1, 24'h008800);
        write_pixel(2, 24'h000090);
        run_frame(3, 0, 0, 1, 4'h5, 8'h11, 0, 4'h0, 8'h00);
        tests++;
        if (obs[1] !== 24'h008800) begin
            fails++;
            $display("FAIL frame_a_untorn got=%06h exp=008800", obs[1]);
        end
        run_frame(1, 0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
        tests++;
        if (obs[1] !== 24'h001100) begin
            fails++;
            $display("FAIL frame_b_update got=%06h exp=001100", obs[1]);
        end
    endtask

    task automatic test_start_ignored();
        run_frame(3, 0, 1, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
        bus_write(4'h9, 8'h3C);
        check_read(4'h9, "bank_sel_kept");
        check_read(4'h1, "bank_sel_kept_b");
    endtask

    task automatic test_invalid_writes();
        bus_write(4'hC, 8'hAA);
        bus_write(4'h3, 8'hBB);
        check_read(4'hC, "oob_pixel");
        check_read(4'h3, "rsvd_channel");
        check_read(4'h0, "p0_green_kept");
        check_read(4'h1, "p0_red_kept");
    endtask

    task automatic test_simultaneous();
        run_frame(1, 0, 0, 0, 4'h0, 8'h00, 1, 4'hA, 8'h5A);
        tests++;
        if (obs[2][23:16] !== 8'h5A) begin
            fails++;
            $display("FAIL sim_write got=%02h exp=5a", obs[2][23:16]);
        end
    endtask

    task automatic test_req_ignored();
        run_frame(2, 1, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
    endtask

    task automatic test_back_to_back();
        run_frame(0, 0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
        run_frame(0, 0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < 12; w++) bus_write(4'($urandom_range(0, 15)), 8'($urandom));
            for (int r = 0; r < 4; r++) check_read(4'($urandom_range(0, 15)), "rand_readback");
            run_frame(int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)), 0, 0,
                      4'h0, 8'h00, 0, 4'h0, 8'h00);
        end
    endtask

    task automatic test_reset_mid_frame();
        int k;
        write_pixel(0, 24'h123456);
        write_pixel(1, 24'hABCDEF);
        FRAME_START = 1'b1;
        cyc();
        FRAME_START = 1'b0;
        msel = !msel;
        k = 0;
        while (PIXEL_VALID !== 1'b1 && k < 20) begin
            cyc();
            k++;
        end
        tests++;
        if (PIXEL_VALID !== 1'b1 || PIXEL_VALUE !== mb[msel][0]) begin
            fails++;
            $display("FAIL pre_reset_pixel got=%06h/v=%b exp=%06h/v=1",
                     PIXEL_VALUE, PIXEL_VALID, mb[msel][0]);
        end
        #10;
        RESET = 1'b1;
        #1;
        tests++;
        if (PIXEL_VALID !== 1'b0 || FRAME_BUSY !== 1'b0 || PIXEL_VALUE !== 24'h0 ||
            BUS_DATA_R !== 8'h00) begin
            fails++;
            $display("FAIL async_reset got v=%b b=%b val=%06h r=%02h exp all zero",
                     PIXEL_VALID, FRAME_BUSY, PIXEL_VALUE, BUS_DATA_R);
        end
        @(negedge clk);
        RESET = 1'b0;
        m_clear();
        cyc();
        check_read(4'h4, "post_reset_readback");
        run_frame(1, 0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
        tests++;
        if (obs[0] !== 24'h0 || obs[1] !== 24'h0 || obs[2] !== 24'h0) begin
            fails++;
            $display("FAIL post_reset_frame got=%06h %06h %06h exp=000000",
                     obs[0], obs[1], obs[2]);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_three_pixels();
        test_mid_frame_write();
        test_start_ignored();
        test_invalid_writes();
        test_simultaneous();
        test_req_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
